// File: rtl/boot_pkg.sv
// Shared types and defaults for the boot ROM -> RAM copy engine.
package boot_pkg;

  localparam int          DEF_ROM_AW  = 5;
  localparam int          DEF_RAM_AW  = 12;
  localparam int          DEF_DW      = 16;
  localparam logic [15:0] DEF_EXP_SUM = 16'h846A;

  // RD: address out, CAP: latch ROM word, WR: push to RAM, DONE: CPU released
  typedef enum logic [1:0] {
    ST_RD   = 2'd0,
    ST_CAP  = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } boot_state_e;

endpackage

// File: rtl/boot_csum.sv
// Running modulo-2^DW sum of captured ROM words, with synchronous clear.
module boot_csum #(
  parameter int DW = 16
) (
  input  logic          romclk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] sum
);

  // clear wins over accumulate; the add wraps naturally at DW bits
  always_ff @(posedge romclk or posedge rst) begin
    if (rst)      sum <= '0;
    else if (clr) sum <= '0;
    else if (en)  sum <= sum + din;
  end

endmodule

// File: rtl/boot_loader.sv
// Boot copy engine: walks every ROM word into RAM at RAM_BASE, keeps a
// checksum, and holds the CPU in reset until the copy has finished.
module boot_loader
  import boot_pkg::*;
#(
  parameter int                ROM_AW   = DEF_ROM_AW,
  parameter int                RAM_AW   = DEF_RAM_AW,
  parameter int                DW       = DEF_DW,
  parameter logic [RAM_AW-1:0] RAM_BASE = '0,
  parameter bit                CHK_EN   = 1'b1,
  parameter logic [DW-1:0]     EXP_SUM  = DEF_EXP_SUM
) (
  input  logic              romclk,
  input  logic              rst,
  input  logic              boot_req,
  output logic              rom_cs,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DW-1:0]     rom_dout,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_din,
  input  logic              ram_ready,
  output logic              cpu_hold,
  output logic              done,
  output logic [DW-1:0]     checksum,
  output logic              boot_err
);

  localparam logic [ROM_AW-1:0] IDX_LAST = '1;

  boot_state_e       state, state_nxt;
  logic [ROM_AW-1:0] idx;
  logic [DW-1:0]     data_q;
  logic              cap_en, idx_inc, restart, err_set;

  // state register
  always_ff @(posedge romclk or posedge rst) begin
    if (rst) state <= ST_RD;
    else     state <= state_nxt;
  end

  // next state and per-state control strobes
  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    idx_inc   = 1'b0;
    restart   = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_RD:  state_nxt = ST_CAP;
      ST_CAP: begin
        cap_en    = 1'b1;
        state_nxt = ST_WR;
      end
      ST_WR: if (ram_ready) begin
        // last-index test comes first so idx never wraps within a copy
        if (idx == IDX_LAST) begin
          err_set   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          idx_inc   = 1'b1;
          state_nxt = ST_RD;
        end
      end
      ST_DONE: if (boot_req) begin
        restart   = 1'b1;
        state_nxt = ST_RD;
      end
      default: state_nxt = ST_RD;
    endcase
  end

  // word index; doubles as the registered ROM address
  always_ff @(posedge romclk or posedge rst) begin
    if (rst)          idx <= '0;
    else if (restart) idx <= '0;
    else if (idx_inc) idx <= idx + 1'b1;
  end

  // ROM word held for the RAM write cycle(s)
  always_ff @(posedge romclk or posedge rst) begin
    if (rst)         data_q <= '0;
    else if (cap_en) data_q <= rom_dout;
  end

  // pass/fail flag, judged once the final word has been summed
  always_ff @(posedge romclk or posedge rst) begin
    if (rst)          boot_err <= 1'b0;
    else if (restart) boot_err <= 1'b0;
    else if (err_set) boot_err <= CHK_EN && (checksum != EXP_SUM);
  end

  boot_csum #(.DW(DW)) u_csum (
    .romclk (romclk),
    .rst    (rst),
    .clr    (restart),
    .en     (cap_en),
    .din    (rom_dout),
    .sum    (checksum)
  );

  // outputs decode straight from the state so reset drops ram_we at once
  always_comb begin
    rom_cs   = (state == ST_RD) || (state == ST_CAP);
    rom_we   = 1'b0;
    rom_addr = idx;
    ram_cs   = (state == ST_WR);
    ram_we   = (state == ST_WR);
    ram_addr = RAM_BASE + RAM_AW'(idx);
    ram_din  = data_q;
    cpu_hold = (state != ST_DONE);
    done     = (state == ST_DONE);
  end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized-image bench for boot_loader against a word-level copy model.
module tb_boot_loader;

  localparam int N = 32;

  logic romclk = 1'b0;
  logic rst = 1'b1;
  logic boot_req = 1'b0;
  logic ram_ready = 1'b1;
  always #5 romclk = ~romclk;

  logic [15:0] rom [0:N-1];

  // main instance (default params)
  logic        rom_cs, rom_we, ram_cs, ram_we, cpu_hold, done, boot_err;
  logic [4:0]  rom_addr;
  logic [15:0] rom_dout, ram_din, checksum;
  logic [11:0] ram_addr;
  // mismatch instances: EXP_SUM=0 with and without checking
  logic        a_rom_cs, a_rom_we, a_ram_cs, a_ram_we, a_cpu_hold, a_done, a_boot_err;
  logic [4:0]  a_rom_addr;
  logic [15:0] a_rom_dout, a_ram_din, a_checksum;
  logic [11:0] a_ram_addr;
  logic        b_rom_cs, b_rom_we, b_ram_cs, b_ram_we, b_cpu_hold, b_done, b_boot_err;
  logic [4:0]  b_rom_addr;
  logic [15:0] b_rom_dout, b_ram_din, b_checksum;
  logic [11:0] b_ram_addr;

  assign rom_dout   = rom[rom_addr];
  assign a_rom_dout = rom[a_rom_addr];
  assign b_rom_dout = rom[b_rom_addr];

  boot_loader dut (
    .romclk(romclk), .rst(rst), .boot_req(boot_req),
    .rom_cs(rom_cs), .rom_we(rom_we), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_ready(ram_ready), .cpu_hold(cpu_hold), .done(done),
    .checksum(checksum), .boot_err(boot_err)
  );

  boot_loader #(.CHK_EN(1'b1), .EXP_SUM(16'h0000)) dut_a (
    .romclk(romclk), .rst(rst), .boot_req(boot_req),
    .rom_cs(a_rom_cs), .rom_we(a_rom_we), .rom_addr(a_rom_addr), .rom_dout(a_rom_dout),
    .ram_cs(a_ram_cs), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_din(a_ram_din),
    .ram_ready(ram_ready), .cpu_hold(a_cpu_hold), .done(a_done),
    .checksum(a_checksum), .boot_err(a_boot_err)
  );

  boot_loader #(.CHK_EN(1'b0), .EXP_SUM(16'h0000)) dut_b (
    .romclk(romclk), .rst(rst), .boot_req(boot_req),
    .rom_cs(b_rom_cs), .rom_we(b_rom_we), .rom_addr(b_rom_addr), .rom_dout(b_rom_dout),
    .ram_cs(b_ram_cs), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
    .ram_ready(ram_ready), .cpu_hold(b_cpu_hold), .done(b_done),
    .checksum(b_checksum), .boot_err(b_boot_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM model: accepts a write on any edge with cs & we & ready
  logic [15:0] ram_mem [0:63];
  int          wr_cnt = 0;
  int          stray_wr = 0;
  logic        ram_clr = 1'b0;

  always @(posedge romclk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= 16'hDEAD;
      wr_cnt   <= 0;
      stray_wr <= 0;
    end else if (ram_cs && ram_we && ram_ready) begin
      wr_cnt <= wr_cnt + 1;
      if (ram_addr < 12'd64) ram_mem[ram_addr[5:0]] <= ram_din;
      else                   stray_wr <= stray_wr + 1;
    end
  end

  logic [15:0] exp_sum;

  task automatic clear_ram();
    @(negedge romclk) ram_clr = 1'b1;
    @(negedge romclk) ram_clr = 1'b0;
  endtask

  // Drive from a negedge until done is seen; returns edges counted.
  // stall: cycles of ram_ready=0 applied while writing word 5.
  // req_at: edge number at which a boot_req pulse is sampled (0 = none).
  task automatic run_copy(input int stall, input int req_at, output int edges);
    int left;
    left  = stall;
    edges = 0;
    for (int k = 0; k < 400; k++) begin
      boot_req = ((edges + 1) == req_at);
      if (left > 0 && ram_cs && ram_we && ram_addr == 12'd5) begin
        ram_ready = 1'b0;
        left--;
        chk("stall_din", ram_din, rom[5]);
        chk("stall_cs", {ram_cs, ram_we}, 2'b11);
      end else begin
        ram_ready = 1'b1;
      end
      @(posedge romclk);
      edges++;
      @(negedge romclk);
      if (done) break;
    end
    boot_req  = 1'b0;
    ram_ready = 1'b1;
  endtask

  task automatic check_ram(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) if (ram_mem[i] !== rom[i]) bad++;
    chk(tag, bad, 0);
    chk({tag, "_wrcnt"}, wr_cnt, N);
    chk({tag, "_stray"}, stray_wr, 0);
  endtask

  // pulse boot_req while in DONE and check the restart edge
  task automatic pulse_req();
    boot_req = 1'b1;
    @(posedge romclk);
    #1;
    boot_req = 1'b0;
    chk("req_hold", cpu_hold, 1'b1);
    chk("req_done", done, 1'b0);
    chk("req_csum", checksum, 16'h0000);
    chk("req_addr", rom_addr, 5'd0);
    @(negedge romclk);
  endtask

  initial begin
    int edges;
    // image: fixed landmark words, random filler, one word trimmed so the
    // 16-bit sum comes out to the standard 846A
    for (int i = 0; i < N; i++) rom[i] = 16'($urandom);
    rom[0]  = 16'hF200;
    rom[1]  = 16'h4000;
    rom[2]  = 16'hF800;
    rom[5]  = 16'h3080;
    rom[31] = 16'hC01E;
    exp_sum = 16'h0000;
    for (int i = 0; i < N; i++) if (i != 30) exp_sum = exp_sum + rom[i];
    rom[30] = 16'h846A - exp_sum;
    exp_sum = 16'h0000;
    for (int i = 0; i < N; i++) exp_sum = exp_sum + rom[i];

    // reset state
    #2;
    chk("rst_outs", {rom_cs, rom_we, ram_cs, ram_we, cpu_hold, done, boot_err},
        7'b1000100);
    chk("rst_addr", rom_addr, 5'd0);
    chk("rst_csum", checksum, 16'h0000);
    clear_ram();
    rst = 1'b0;

    // plain copy
    run_copy(0, 0, edges);
    chk("s1_edges", edges, 3 * N);
    chk("s1_csum", checksum, exp_sum);
    chk("s1_flags", {done, cpu_hold, boot_err, rom_cs, ram_cs}, 5'b10000);
    check_ram("s1_ram");
    chk("a_err", {a_done, a_boot_err}, 2'b11);
    chk("b_err", {b_done, b_boot_err}, 2'b10);
    chk("a_lock", {a_rom_cs, a_rom_we, a_rom_addr, a_ram_cs, a_ram_we, a_ram_addr,
                   a_ram_din, a_cpu_hold, a_checksum} ===
                  {rom_cs, rom_we, rom_addr, ram_cs, ram_we, ram_addr,
                   ram_din, cpu_hold, checksum}, 1'b1);
    chk("b_lock", {b_rom_cs, b_rom_we, b_rom_addr, b_ram_cs, b_ram_we, b_ram_addr,
                   b_ram_din, b_cpu_hold, b_checksum} ===
                  {rom_cs, rom_we, rom_addr, ram_cs, ram_we, ram_addr,
                   ram_din, cpu_hold, checksum}, 1'b1);
    repeat (5) @(negedge romclk);
    chk("done_stable", {done, checksum}, {1'b1, exp_sum});

    // restart from DONE
    pulse_req();
    run_copy(0, 0, edges);
    chk("s2_edges", edges, 3 * N);
    chk("s2_csum", checksum, exp_sum);
    chk("s2_err", {done, boot_err, a_boot_err}, 3'b101);

    // RAM back-pressure on word 5
    clear_ram();
    pulse_req();
    run_copy(2, 0, edges);
    chk("s3_edges", edges, 3 * N + 2);
    chk("s3_csum", checksum, exp_sum);
    check_ram("s3_ram");

    // boot_req mid-copy is ignored
    rst = 1'b1;
    @(negedge romclk);
    rst = 1'b0;
    run_copy(0, 20, edges);
    chk("s4_edges", edges, 3 * N);
    chk("s4_csum", checksum, exp_sum);

    // reset mid-copy
    rst = 1'b1;
    @(negedge romclk);
    rst = 1'b0;
    repeat (40) @(posedge romclk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_outs", {rom_cs, ram_cs, ram_we, cpu_hold, done, boot_err}, 6'b100100);
    chk("mid_addr", rom_addr, 5'd0);
    chk("mid_csum", checksum, 16'h0000);
    repeat (3) @(negedge romclk);
    rst = 1'b0;
    run_copy(0, 0, edges);
    chk("s5_edges", edges, 3 * N);
    chk("s5_csum", checksum, exp_sum);
    chk("s5_err", boot_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
